// File: rtl/risc_dmem_arbiter.sv
// rtl/risc_dmem_arbiter.sv - data-memory arbiter between the EU load/store path and the loader port
//
// Shares one single-port 16x8 data memory between the execution unit (EU) and
// a loader/debug port (LD). Each access is IDLE -> ACCESS (WAIT_CYCLES+1 cycles)
// -> RESP (one-cycle done pulse) -> IDLE. EU has fixed priority, but after
// LD_MAX_WAIT consecutive losses the loader wins the next contested arbitration.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   eu_req/eu_rdwr/eu_addr/eu_wdata   EU request, 1=read, word address, store data
//   eu_rdata, eu_done, stall      last EU read data, EU completion pulse, pipeline hold
//   ld_req/ld_we/ld_addr/ld_wdata     loader request, 1=write, word address, write data
//   ld_rdata, ld_done, ld_gnt     last loader read data, completion pulse, loader owns memory
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobes, driven only during ACCESS
//   mem_rdata                     memory read data, valid in the last ACCESS cycle

module risc_dmem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int LD_MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       eu_req,
  input  logic       eu_rdwr,
  input  logic [3:0] eu_addr,
  input  logic [7:0] eu_wdata,
  output logic [7:0] eu_rdata,
  output logic       eu_done,
  output logic       stall,
  input  logic       ld_req,
  input  logic       ld_we,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_wdata,
  output logic [7:0] ld_rdata,
  output logic       ld_done,
  output logic       ld_gnt,
  output logic       mem_en,
  output logic       mem_we,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_next;
  logic          owner_ld;   // 0 = EU owns the access, 1 = loader
  logic [CW-1:0] cnt;
  logic [3:0]    loss;
  logic [3:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          we_q;
  logic          grant_eu, grant_ld;

  // Contested arbitration goes to the loader once it has lost LD_MAX_WAIT times.
  always_comb begin
    grant_eu = 1'b0;
    grant_ld = 1'b0;
    if (eu_req && ld_req) begin
      if (loss < 4'(LD_MAX_WAIT)) grant_eu = 1'b1;
      else                        grant_ld = 1'b1;
    end else if (eu_req) begin
      grant_eu = 1'b1;
    end else if (ld_req) begin
      grant_ld = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 4'd0;
    mem_wdata  = 8'd0;
    eu_done    = 1'b0;
    ld_done    = 1'b0;
    ld_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_eu || grant_ld) state_next = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        ld_gnt    = owner_ld;
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        eu_done    = ~owner_ld;
        ld_done    = owner_ld;
        ld_gnt     = owner_ld;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by rst so the hold also reads 0 while the block is held in reset.
  assign stall = eu_req & ~eu_done & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_ld <= 1'b0;
      cnt      <= '0;
      loss     <= 4'd0;
      addr_q   <= 4'd0;
      wdata_q  <= 8'd0;
      we_q     <= 1'b0;
      eu_rdata <= 8'd0;
      ld_rdata <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_eu) begin
            owner_ld <= 1'b0;
            addr_q   <= eu_addr;
            wdata_q  <= eu_wdata;
            we_q     <= ~eu_rdwr;
            cnt      <= CW'(WAIT_CYCLES);
            // A contested EU win only happens while loss < LD_MAX_WAIT,
            // so the increment saturates at LD_MAX_WAIT by construction.
            if (ld_req) loss <= loss + 4'd1;
          end else if (grant_ld) begin
            owner_ld <= 1'b1;
            addr_q   <= ld_addr;
            wdata_q  <= ld_wdata;
            we_q     <= ld_we;
            cnt      <= CW'(WAIT_CYCLES);
            loss     <= 4'd0;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!we_q) begin
            if (owner_ld) ld_rdata <= mem_rdata;
            else          eu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_dmem_arbiter.sv
// tb/tb_risc_dmem_arbiter.sv - self-checking bench for risc_dmem_arbiter

module tb_risc_dmem_arbiter;

  localparam int W1 = 2;
  localparam int M1 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: WAIT_CYCLES=2, LD_MAX_WAIT=2
  logic       eu_req = 0, eu_rdwr = 0, ld_req = 0, ld_we = 0;
  logic [3:0] eu_addr = 0, ld_addr = 0;
  logic [7:0] eu_wdata = 0, ld_wdata = 0;
  logic [7:0] eu_rdata, ld_rdata, mem_wdata, mem_rdata;
  logic       eu_done, stall, ld_done, ld_gnt, mem_en, mem_we;
  logic [3:0] mem_addr;

  // second instance: WAIT_CYCLES=0
  logic       eu2_req = 0, eu2_rdwr = 0;
  logic [3:0] eu2_addr = 0;
  logic [7:0] eu2_wdata = 0;
  logic [7:0] eu2_rdata, ld2_rdata, mem2_wdata, mem2_rdata;
  logic       eu2_done, stall2, ld2_done, ld2_gnt, mem2_en, mem2_we;
  logic [3:0] mem2_addr;
  logic       ld2_req = 0, ld2_we = 0;
  logic [3:0] ld2_addr = 0;
  logic [7:0] ld2_wdata = 0;

  risc_dmem_arbiter #(.WAIT_CYCLES(W1), .LD_MAX_WAIT(M1)) u_dut (
    .clk(clk), .rst(rst),
    .eu_req(eu_req), .eu_rdwr(eu_rdwr), .eu_addr(eu_addr), .eu_wdata(eu_wdata),
    .eu_rdata(eu_rdata), .eu_done(eu_done), .stall(stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done), .ld_gnt(ld_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  risc_dmem_arbiter #(.WAIT_CYCLES(0), .LD_MAX_WAIT(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .eu_req(eu2_req), .eu_rdwr(eu2_rdwr), .eu_addr(eu2_addr), .eu_wdata(eu2_wdata),
    .eu_rdata(eu2_rdata), .eu_done(eu2_done), .stall(stall2),
    .ld_req(ld2_req), .ld_we(ld2_we), .ld_addr(ld2_addr), .ld_wdata(ld2_wdata),
    .ld_rdata(ld2_rdata), .ld_done(ld2_done), .ld_gnt(ld2_gnt),
    .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata)
  );

  // memories attached to the DUT memory ports
  logic [7:0] emem [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA7, 8'h66, 8'h77,
                            8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0};
  logic [7:0] emem2 [16] = '{default: 8'h00};
  assign mem_rdata  = emem[mem_addr];
  assign mem2_rdata = emem2[mem2_addr];
  always @(posedge clk) if (mem_en && mem_we) emem[mem_addr] <= mem_wdata;
  always @(posedge clk) if (mem2_en && mem2_we) emem2[mem2_addr] <= mem2_wdata;

  // Transaction-level reference: an access granted at edge g occupies memory
  // in cycles g..g+W, responds in cycle g+W+1, and the next grant is possible
  // at edge g+W+3 at the earliest.
  int         e, g, loss;
  bit         act, m_ld, m_we, x_acc, x_resp;
  logic [3:0] m_addr;
  logic [7:0] m_wd, m_eu_rd, m_ld_rd;
  logic [7:0] mm [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA7, 8'h66, 8'h77,
                          8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act = 0; loss = 0; e = 0; g = 0; m_eu_rd = 8'h00; m_ld_rd = 8'h00;
    end else begin
      e = e + 1;
      if (act && e == g + W1 + 1) begin
        if (m_we)      mm[m_addr] = m_wd;
        else if (m_ld) m_ld_rd = mm[m_addr];
        else           m_eu_rd = mm[m_addr];
      end
      if (act && e >= g + W1 + 3) act = 0;
      if (!act) begin
        if (eu_req && (!ld_req || loss < M1)) begin
          act = 1; g = e; m_ld = 0; m_addr = eu_addr; m_wd = eu_wdata; m_we = !eu_rdwr;
          if (ld_req) loss = loss + 1;
        end else if (ld_req) begin
          act = 1; g = e; m_ld = 1; m_addr = ld_addr; m_wd = ld_wdata; m_we = ld_we;
          loss = 0;
        end
      end
    end
    x_acc  = act && (e - g) <= W1;
    x_resp = act && (e - g) == W1 + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp_v, $time);
    end
  endtask

  task automatic compare_all();
    bit xd_eu, xd_ld;
    xd_eu = x_resp && !m_ld;
    xd_ld = x_resp && m_ld;
    chk("mem_en", 32'(mem_en), 32'(x_acc));
    chk("mem_we", 32'(mem_we), 32'(x_acc && m_we));
    if (x_acc) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
    end
    chk("eu_done", 32'(eu_done), 32'(xd_eu));
    chk("ld_done", 32'(ld_done), 32'(xd_ld));
    chk("ld_gnt", 32'(ld_gnt), 32'((x_acc || x_resp) && m_ld));
    chk("stall", 32'(stall), 32'(eu_req && !xd_eu));
    chk("eu_rdata", 32'(eu_rdata), 32'(m_eu_rd));
    chk("ld_rdata", 32'(ld_rdata), 32'(m_ld_rd));
  endtask

  // One cycle: check at the falling edge, return 2 time units after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst) compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic eu_op(input bit rdwr, input logic [3:0] a, input logic [7:0] d,
                       output int edges, output int en_cyc, output int stall_bad,
                       output logic [3:0] first_addr);
    eu_rdwr = rdwr; eu_addr = a; eu_wdata = d; eu_req = 1;
    edges = 0; en_cyc = 0; stall_bad = 0; first_addr = 4'd0;
    while (edges < 30) begin
      step();
      edges++;
      if (edges == 1) first_addr = mem_addr;
      if (mem_en) en_cyc++;
      if (eu_done) begin
        eu_req = 0;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
    end
  endtask

  task automatic ld_op(input bit we, input logic [3:0] a, input logic [7:0] d,
                       output int edges);
    ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1;
    edges = 0;
    while (edges < 30) begin
      step();
      edges++;
      if (ld_done) begin
        ld_req = 0;
        break;
      end
    end
  endtask

  initial begin
    int         edges, en_cyc, stall_bad, n, en2;
    logic [3:0] fa;
    int         seq [6];
    bit         eu_rearm, ld_rearm, stop_new;

    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_eu_done", 32'(eu_done), 0);
    chk("rst_eu_rdata", 32'(eu_rdata), 0);
    chk("rst_ld_rdata", 32'(ld_rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst = 0;
    step();
    step();

    // EU read of memory[5] = A7
    eu_op(1'b1, 4'd5, 8'h00, edges, en_cyc, stall_bad, fa);
    chk("eu_rd_done_cycle", 32'(edges), 4);
    chk("eu_rd_en_cycles", 32'(en_cyc), 3);
    chk("eu_rd_addr", 32'(fa), 5);
    chk("eu_rd_stall", 32'(stall_bad), 0);
    step();
    chk("eu_rd_data", 32'(eu_rdata), 32'h A7);

    // loader write then EU read of the same word
    ld_op(1'b1, 4'd3, 8'h3C, edges);
    chk("ld_wr_done_cycle", 32'(edges), 4);
    step();
    chk("ld_wr_mem", 32'(emem[3]), 32'h3C);
    eu_op(1'b1, 4'd3, 8'h00, edges, en_cyc, stall_bad, fa);
    chk("eu_rd3_done_cycle", 32'(edges), 4);
    step();
    chk("eu_rd3_data", 32'(eu_rdata), 32'h3C);
    chk("ld_rdata_kept", 32'(ld_rdata), 0);

    // both requesters held: EU, EU, LD, then the cleared loss count repeats it
    n = 0; eu_rearm = 0; ld_rearm = 0;
    eu_rdwr = 1; eu_addr = 4'd1; ld_we = 0; ld_addr = 4'd2;
    eu_req = 1; ld_req = 1;
    for (int c = 0; c < 200 && n < 6; c++) begin
      step();
      if (eu_rearm) begin eu_req = 1; eu_rearm = 0; end
      if (ld_rearm) begin ld_req = 1; ld_rearm = 0; end
      if (eu_done && n < 6) begin seq[n] = 0; n++; eu_req = 0; eu_rearm = 1; end
      if (ld_done && n < 6) begin seq[n] = 1; n++; ld_req = 0; ld_rearm = 1; end
    end
    eu_req = 0; ld_req = 0;
    chk("starve_count", 32'(n), 6);
    chk("starve_0", 32'(seq[0]), 0);
    chk("starve_1", 32'(seq[1]), 0);
    chk("starve_2", 32'(seq[2]), 1);
    chk("starve_3", 32'(seq[3]), 0);
    chk("starve_4", 32'(seq[4]), 0);
    chk("starve_5", 32'(seq[5]), 1);
    repeat (3) step();

    // reset during the second ACCESS cycle of an EU store
    eu_rdwr = 0; eu_addr = 4'd9; eu_wdata = mm[9]; eu_req = 1;
    step();
    chk("rstacc_en1", 32'(mem_en), 1);
    step();
    chk("rstacc_we2", 32'(mem_we), 1);
    #1 rst = 1;
    #1;
    chk("rstacc_en", 32'(mem_en), 0);
    chk("rstacc_we", 32'(mem_we), 0);
    chk("rstacc_done", 32'(eu_done), 0);
    chk("rstacc_stall", 32'(stall), 0);
    chk("rstacc_eu_rdata", 32'(eu_rdata), 0);
    eu_req = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rstacc_no_done", 32'(eu_done), 0);
    end
    rst = 0;
    step();
    eu_op(1'b1, 4'd3, 8'h00, edges, en_cyc, stall_bad, fa);
    chk("post_rst_done_cycle", 32'(edges), 4);
    step();
    chk("post_rst_data", 32'(eu_rdata), 32'h3C);

    // WAIT_CYCLES = 0 instance: store 8'hFF to address 15
    eu2_rdwr = 0; eu2_addr = 4'd15; eu2_wdata = 8'hFF; eu2_req = 1;
    edges = 0; en2 = 0;
    while (edges < 20) begin
      step();
      edges++;
      if (mem2_en) begin
        en2++;
        chk("w0_we", 32'(mem2_we), 1);
        chk("w0_addr", 32'(mem2_addr), 15);
      end
      if (eu2_done) begin
        chk("w0_stall", 32'(stall2), 0);
        eu2_req = 0;
        break;
      end
    end
    chk("w0_done_cycle", 32'(edges), 2);
    chk("w0_en_cycles", 32'(en2), 1);
    step();
    chk("w0_rdata", 32'(eu2_rdata), 0);
    chk("w0_mem", 32'(emem2[15]), 32'hFF);
    chk("w0_ld_side", 32'({ld2_done, ld2_gnt, ld2_rdata}), 0);

    // random traffic on the main instance against the reference
    stop_new = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c >= 2900) stop_new = 1;
      step();
      if (eu_req) begin
        if (x_resp && !m_ld) eu_req = 0;
      end else if (!stop_new && $urandom_range(0, 2) == 0) begin
        eu_req = 1; eu_rdwr = 1'($urandom_range(0, 1));
        eu_addr = 4'($urandom_range(0, 15)); eu_wdata = 8'($urandom);
      end
      if (ld_req) begin
        if (x_resp && m_ld) ld_req = 0;
      end else if (!stop_new && $urandom_range(0, 3) == 0) begin
        ld_req = 1; ld_we = 1'($urandom_range(0, 1));
        ld_addr = 4'($urandom_range(0, 15)); ld_wdata = 8'($urandom);
      end
    end
    chk("drain_idle", 32'({eu_req, ld_req}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_dmem_arbiter.md
Name: risc_dmem_arbiter

Overview:
- Sequences every data-memory access in the RISC core.
- Shares one single-port 16x8 data memory between two requesters:
  - the execution unit's load/store path (EU port);
  - a loader/debug port (LD port) that preloads or inspects memory.
- Memory accesses take a fixed, configurable number of wait states.
- Stalls the pipeline while an EU access is in progress.
- Fixed EU priority, with a starvation guard for the loader.

Parameters:
WAIT_CYCLES, 2, extra cycles the memory needs per access (0..15); access phase lasts WAIT_CYCLES+1 cycles
LD_MAX_WAIT, 4, consecutive arbitration losses after which LD wins the next arbitration (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
eu_req  in  1  EU access request (driven from the EU memory-enable)
eu_rdwr  in  1  1 = read (load), 0 = write (store)
eu_addr  in  4  EU word address
eu_wdata  in  8  EU store data
eu_rdata  out  8  last data read for EU
eu_done  out  1  one-cycle pulse: EU access complete
stall  out  1  pipeline hold; combinational: eu_req & ~eu_done
ld_req  in  1  loader access request
ld_we  in  1  1 = write, 0 = read
ld_addr  in  4  loader word address
ld_wdata  in  8  loader write data
ld_rdata  out  8  last data read for loader
ld_done  out  1  one-cycle pulse: loader access complete
ld_gnt  out  1  loader owns memory (ACCESS or RESP with owner = LD)
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  4  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data; valid in the last access cycle

Behaviour:
Reset (rst high, asynchronous):
- state = IDLE; owner = EU; wait counter = 0; loss counter = 0.
- All outputs 0, including eu_rdata, ld_rdata, mem_* and both done pulses.
- An access in flight is abandoned. No done pulse is produced, and no write completes after reset asserts.

Requester contract:
- Hold req and all operands stable until that port's done pulse.
- Deassert req in the done cycle. If req is still high when IDLE is re-entered, it is a new request.

State machine:
- IDLE (mem_en = 0): arbitrate at each rising edge.
  - If the winner exists, latch owner, addr, wdata and we (EU: we = ~eu_rdwr). Load wait counter = WAIT_CYCLES. Go to ACCESS.
- ACCESS: drive the latched values.
  - mem_en = 1, mem_we = latched we, mem_addr and mem_wdata stable for all WAIT_CYCLES+1 cycles.
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0: if it is a read, capture mem_rdata into the owner's rdata register. Go to RESP.
- RESP (mem_en = 0): owner's done = 1 for exactly this cycle. Next edge goes to IDLE.
  - No arbitration happens in RESP.
- Latency: request sampled at edge E0; done is high in the cycle after edge E(WAIT_CYCLES+1).
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.

Arbitration (IDLE only):
- Only eu_req high: EU wins.
- Only ld_req high: LD wins; loss counter is cleared.
- Both high:
  - EU wins and the loss counter increments (saturating) if loss counter < LD_MAX_WAIT.
  - Otherwise LD wins and the loss counter is cleared.
- Neither high: stay in IDLE; loss counter unchanged.

Other rules:
- Writes leave eu_rdata and ld_rdata unchanged. Each rdata register holds its value until that port's next read completes.
- stall stays high through ACCESS even while LD owns memory. It falls in the EU done cycle.
- WAIT_CYCLES = 0 is legal: ACCESS lasts 1 cycle.
- Wait counter width = max(1, clog2(WAIT_CYCLES+1)). Loss counter is 4 bits.

Test Plan:
- Reset: assert rst mid-run → all outputs 0 immediately, without waiting for a clock edge; state IDLE on release.
- EU read, WAIT_CYCLES=2, memory[5]=8'hA7: eu_req=1, eu_rdwr=1, eu_addr=5 at edge 0 → mem_en high for 3 cycles with mem_addr=5; eu_done pulses in cycle 4; eu_rdata=8'hA7; stall high in cycles 0-3.
- Loader write then EU read: ld_we=1, ld_addr=3, ld_wdata=8'h3C → ld_done pulse; memory[3]=8'h3C. Then EU load from 3 → eu_rdata=8'h3C; ld_rdata stays 0.
- Simultaneous requests, LD_MAX_WAIT=2, both reqs held continuously (EU re-requests after each done):
  - EU wins twice, then LD wins the third arbitration.
  - The loss counter is cleared after the LD win.
- Reset mid-access: assert rst during the 2nd ACCESS cycle of an EU store → mem_en and mem_we drop at once; no eu_done pulse; after release, a new EU request completes normally.
- WAIT_CYCLES=0: EU store addr=15, data=8'hFF → mem_en high for exactly 1 cycle; eu_done in the next cycle; eu_rdata unchanged.
